// File: rtl/placar_pkg.sv
// Shared types and constants for the placar scoreboard: conversion FSM states
// and the 7-segment pattern table (bit 6 = a ... bit 0 = g, active-high).
package placar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } dabble_state_e;

    // Entry [d] is the segment pattern for decimal digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
        7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        if (d <= 4'd9) begin
            return SEG_TABLE[d];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/placar_dabble.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// done pulses for one cycle while bcd_o carries the finished result.
module placar_dabble
    import placar_pkg::*;
#(
    parameter int SCORE_W = 7,
    parameter int DIGITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [SCORE_W-1:0]    bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + SCORE_W;
    localparam int CNT_W  = $clog2(SCORE_W + 1);

    dabble_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORK_W-1:0]  work_q;
    logic               shift_en;
    logic               load_en;

    // Adjust every BCD nibble >= 5 before the shift so it carries correctly.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[SCORE_W+4*i +: 4] >= 4'd5) begin
                t[SCORE_W+4*i +: 4] = t[SCORE_W+4*i +: 4] + 4'd3;
            end
        end
        return t << 1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state_q != IDLE);
        shift_en = (state_q == SHIFT);
        load_en  = (state_q == LOAD);
        done_o   = load_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            cnt_q <= '0;
        end else if (shift_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && start_i) begin
            work_q <= {{BCD_W{1'b0}}, bin_i};
        end else if (shift_en) begin
            work_q <= dabble_step(work_q);
        end
    end

    assign bcd_o = work_q[WORK_W-1 -: BCD_W];

endmodule

// File: rtl/placar_mux.sv
// Saturating scoreboard with multiplexed 7-segment display.
// Optional macro PLACAR_BLANK_ZEROS_EN blanks leading zeros above the units digit.
module placar_mux
    import placar_pkg::*;
#(
    parameter int  DIGITS    = 2,
    parameter int  MAX_SCORE = 99,
    parameter int  PTS_W     = 7,
    parameter int  SCAN_DIV  = 50000,
    localparam int SCORE_W   = $clog2(MAX_SCORE + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                sinal,
    input  logic [PTS_W-1:0]    pontos,
    input  logic                clear_alert,
    output logic [SCORE_W-1:0]  score,
    output logic                alerta,
    output logic [6:0]          saida,
    output logic [DIGITS-1:0]   sclk
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int EXT_W  = SCORE_W + PTS_W + 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_SCORE);

    logic [SCORE_W-1:0]        score_q, score_d;
    logic                      alerta_q, alerta_d;
    logic [BCD_W-1:0]          disp_q;
    logic [SCAN_W-1:0]         scan_q;
    logic [IDX_W-1:0]          dig_q;
    logic                      accept;
    logic                      clamp;
    logic                      dab_busy;
    logic                      dab_done;
    logic [BCD_W-1:0]          dab_bcd;
    logic signed [EXT_W-1:0]   score_ext;
    logic signed [EXT_W-1:0]   pts_ext;
    logic signed [EXT_W-1:0]   res_ext;
    logic [3:0]                sel_digit;
    logic                      scan_wrap;

    function automatic logic [SCORE_W-1:0] sat_score(input logic signed [EXT_W-1:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > MAX_EXT) begin
            return SCORE_W'(MAX_SCORE);
        end
        return v[SCORE_W-1:0];
    endfunction

    // Landing exactly on 0 or MAX_SCORE is legal and does not count as clamping.
    function automatic logic is_clamped(input logic signed [EXT_W-1:0] v);
        return (v < 0) || (v > MAX_EXT);
    endfunction

    assign op_ready = ~dab_busy;
    assign accept   = op_valid & op_ready;

    always_comb begin
        score_ext = $signed({{(PTS_W + 1){1'b0}}, score_q});
        pts_ext   = $signed({{(SCORE_W + 1){1'b0}}, pontos});
        res_ext   = sinal ? (score_ext - pts_ext) : (score_ext + pts_ext);
        score_d   = score_q;
        clamp     = 1'b0;
        if (accept) begin
            score_d = sat_score(res_ext);
            clamp   = is_clamped(res_ext);
        end
    end

    always_comb begin
        alerta_d = alerta_q;
        if (accept && clamp) begin
            alerta_d = 1'b1;
        end else if (clear_alert) begin
            alerta_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q  <= '0;
            alerta_q <= 1'b0;
        end else begin
            score_q  <= score_d;
            alerta_q <= alerta_d;
        end
    end

    // The converter sees the post-operation score on the accept edge.
    placar_dabble #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_dabble (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept),
        .bin_i   (score_d),
        .busy_o  (dab_busy),
        .done_o  (dab_done),
        .bcd_o   (dab_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= '0;
        end else if (dab_done) begin
            disp_q <= dab_bcd;
        end
    end

    assign scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            dig_q  <= '0;
        end else if (scan_wrap) begin
            scan_q <= '0;
            dig_q  <= (dig_q == IDX_W'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    always_comb begin
        sclk      = '0;
        sel_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q == IDX_W'(i)) begin
                sclk[i]   = 1'b1;
                sel_digit = disp_q[4*i +: 4];
            end
        end
    end

`ifdef PLACAR_BLANK_ZEROS_EN
    logic [DIGITS-1:0] blank_mask;
    logic              zero_run;
    logic              sel_blank;

    // A digit is blank when it and every digit above it are zero.
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        sel_blank  = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (disp_q[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_run;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q == IDX_W'(i)) begin
                sel_blank = blank_mask[i];
            end
        end
    end

    assign saida = sel_blank ? SEG_BLANK : seg_decode(sel_digit);
`else
    assign saida = seg_decode(sel_digit);
`endif

    assign score  = score_q;
    assign alerta = alerta_q;

endmodule

// File: tb/tb_placar_mux.sv
// Directed bench for placar_mux with DIGITS=2, MAX_SCORE=99, SCAN_DIV=4.
// Honours PLACAR_BLANK_ZEROS_EN when the design is built with it.
module tb_placar_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic       sinal = 1'b0;
    logic [6:0] pontos = '0;
    logic       clear_alert = 1'b0;
    logic [6:0] score;
    logic       alerta;
    logic [6:0] saida;
    logic [1:0] sclk;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    placar_mux #(
        .DIGITS    (2),
        .MAX_SCORE (99),
        .PTS_W     (7),
        .SCAN_DIV  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .sinal       (sinal),
        .pontos      (pontos),
        .clear_alert (clear_alert),
        .score       (score),
        .alerta      (alerta),
        .saida       (saida),
        .sclk        (sclk)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h7E;
            1: return 7'h30;
            2: return 7'h6D;
            3: return 7'h79;
            4: return 7'h33;
            5: return 7'h5B;
            6: return 7'h5F;
            7: return 7'h70;
            8: return 7'h7F;
            9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_saida(input logic [1:0] sc, input int val);
        if (sc == 2'b01) return seg(val % 10);
`ifdef PLACAR_BLANK_ZEROS_EN
        if (val / 10 == 0) return 7'h00;
`endif
        return seg(val / 10);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        op_valid = 1'b0;
        clear_alert = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!op_ready && n < 30) begin
            tick();
            n++;
        end
        if (!op_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: op_ready=%b after %0d cycles, need 1", op_ready, n);
        end
    endtask

    task automatic do_op(input logic s, input int p);
        wait_ready();
        op_valid = 1'b1;
        sinal    = s;
        pontos   = 7'(p);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_op(1'b0, 37);
        do_reset();
        total++; if (score !== 7'd0)    begin bad++; $display("FAIL rst_score: got %0d want 0", score); end
        total++; if (alerta !== 1'b0)   begin bad++; $display("FAIL rst_alerta: got %b want 0", alerta); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", op_ready); end
        total++; if (sclk !== 2'b01)    begin bad++; $display("FAIL rst_sclk: got %b want 01", sclk); end
        total++; if (saida !== 7'h7E)   begin bad++; $display("FAIL rst_saida: got %h want 7e", saida); end
    endtask

    task automatic test_add45();
        int n;
        int run;
        int changes;
        logic [1:0] prev;
        do_reset();
        do_op(1'b0, 45);
        total++; if (score !== 7'd45) begin bad++; $display("FAIL add45_score: got %0d want 45", score); end
        n = 0;
        while (!op_ready && n < 20) begin
            total++;
            if (saida !== exp_saida(sclk, 0)) begin
                bad++; $display("FAIL add45_hold_display: got %h want %h", saida, exp_saida(sclk, 0));
            end
            n++;
            tick();
        end
        total++; if (n != 8) begin bad++; $display("FAIL add45_busy_len: got %0d want 8", n); end
        run = 0;
        changes = 0;
        prev = sclk;
        for (int k = 0; k < 16; k++) begin
            total++;
            if (!(sclk == 2'b01 || sclk == 2'b10)) begin
                bad++; $display("FAIL add45_onehot: got %b", sclk);
            end
            total++;
            if (saida !== exp_saida(sclk, 45)) begin
                bad++; $display("FAIL add45_saida: sclk=%b got %h want %h", sclk, saida, exp_saida(sclk, 45));
            end
            if (k > 0 && sclk != prev) begin
                if (changes > 0) begin
                    total++;
                    if (run != 4) begin bad++; $display("FAIL add45_scan_period: got %0d want 4", run); end
                end
                changes++;
                run = 1;
            end else begin
                run++;
            end
            prev = sclk;
            tick();
        end
        total++; if (changes < 3) begin bad++; $display("FAIL add45_scan_changes: got %0d want >=3", changes); end
    endtask

    task automatic test_saturate();
        do_reset();
        do_op(1'b0, 90);
        do_op(1'b0, 9);
        total++; if (score !== 7'd99) begin bad++; $display("FAIL exact_max_score: got %0d want 99", score); end
        total++; if (alerta !== 1'b0) begin bad++; $display("FAIL exact_max_alerta: got %b want 0", alerta); end
        do_reset();
        do_op(1'b0, 90);
        do_op(1'b0, 20);
        total++; if (score !== 7'd99) begin bad++; $display("FAIL sat_score: got %0d want 99", score); end
        total++; if (alerta !== 1'b1) begin bad++; $display("FAIL sat_alerta: got %b want 1", alerta); end
        wait_ready();
        total++; if (alerta !== 1'b1) begin bad++; $display("FAIL sat_sticky: got %b want 1", alerta); end
        clear_alert = 1'b1;
        tick();
        clear_alert = 1'b0;
        total++; if (alerta !== 1'b0) begin bad++; $display("FAIL clear_alerta: got %b want 0", alerta); end
    endtask

    task automatic test_subtract();
        do_reset();
        do_op(1'b0, 3);
        do_op(1'b1, 10);
        total++; if (score !== 7'd0)  begin bad++; $display("FAIL under_score: got %0d want 0", score); end
        total++; if (alerta !== 1'b1) begin bad++; $display("FAIL under_alerta: got %b want 1", alerta); end
        do_reset();
        do_op(1'b0, 10);
        do_op(1'b1, 10);
        total++; if (score !== 7'd0)  begin bad++; $display("FAIL exact_zero_score: got %0d want 0", score); end
        total++; if (alerta !== 1'b0) begin bad++; $display("FAIL exact_zero_alerta: got %b want 0", alerta); end
        do_op(1'b0, 50);
        do_op(1'b1, 17);
        total++; if (score !== 7'd33) begin bad++; $display("FAIL sub_score: got %0d want 33", score); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int n;
        do_reset();
        wait_ready();
        op_valid = 1'b1;
        sinal    = 1'b0;
        pontos   = 7'd1;
        for (int c = 0; c < 45; c++) begin
            if (op_ready) acc++;
            tick();
        end
        op_valid = 1'b0;
        wait_ready();
        total++; if (acc != 5)       begin bad++; $display("FAIL b2b_accepts: got %0d want 5", acc); end
        total++; if (score !== 7'd5) begin bad++; $display("FAIL b2b_score: got %0d want 5", score); end
        n = 0;
        while (sclk != 2'b01 && n < 10) begin tick(); n++; end
        total++; if (saida !== exp_saida(2'b01, 5)) begin bad++; $display("FAIL b2b_units: got %h want %h", saida, exp_saida(2'b01, 5)); end
        n = 0;
        while (sclk != 2'b10 && n < 10) begin tick(); n++; end
        total++; if (saida !== exp_saida(2'b10, 5)) begin bad++; $display("FAIL b2b_tens: got %h want %h", saida, exp_saida(2'b10, 5)); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        do_op(1'b0, 11);
        do_op(1'b0, 66);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (score !== 7'd0)    begin bad++; $display("FAIL mid_rst_score: got %0d want 0", score); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", op_ready); end
        total++; if (sclk !== 2'b01)    begin bad++; $display("FAIL mid_rst_sclk: got %b want 01", sclk); end
        total++; if (saida !== 7'h7E)   begin bad++; $display("FAIL mid_rst_units: got %h want 7e", saida); end
        for (int k = 0; k < 4; k++) tick();
        total++; if (sclk !== 2'b10)    begin bad++; $display("FAIL mid_rst_sclk2: got %b want 10", sclk); end
        total++; if (saida !== exp_saida(2'b10, 0)) begin bad++; $display("FAIL mid_rst_tens: got %h want %h", saida, exp_saida(2'b10, 0)); end
        op_valid = 1'b1;
        pontos   = 7'd50;
        sinal    = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        op_valid = 1'b0;
        total++; if (score !== 7'd0)    begin bad++; $display("FAIL rst_vs_accept_score: got %0d want 0", score); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rst_vs_accept_ready: got %b want 1", op_ready); end
    endtask

    task automatic test_clear_same_edge();
        do_reset();
        do_op(1'b0, 90);
        wait_ready();
        op_valid    = 1'b1;
        sinal       = 1'b0;
        pontos      = 7'd20;
        clear_alert = 1'b1;
        tick();
        op_valid    = 1'b0;
        clear_alert = 1'b0;
        total++; if (alerta !== 1'b1) begin bad++; $display("FAIL set_beats_clear: got %b want 1", alerta); end
        total++; if (score !== 7'd99) begin bad++; $display("FAIL set_beats_clear_score: got %0d want 99", score); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_add45();
        test_saturate();
        test_subtract();
        test_back_to_back();
        test_rst_mid();
        test_clear_same_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
